// File: rtl/cache_pkg.sv
// Shared types and constants for the 4-way tag lookup controller.
package cache_pkg;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned WAY_W = 2;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_INVAL = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_FILL      = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  // The reserved encoding behaves exactly like a read.
  function automatic op_e norm_op(input logic [1:0] raw);
    case (raw)
      2'd1:    return OP_WRITE;
      2'd2:    return OP_INVAL;
      default: return OP_READ;
    endcase
  endfunction

endpackage

// File: rtl/way_tag_compare.sv
// Combinational tag match across all ways, plus lowest-index invalid way.
module way_tag_compare
  import cache_pkg::*;
#(
  parameter int unsigned TAG_W = 12
) (
  input  logic [WAYS-1:0][TAG_W-1:0] tags_i,
  input  logic [WAYS-1:0]            valid_i,
  input  logic [TAG_W-1:0]           tag_i,
  output logic                       hit_o,
  output logic [WAY_W-1:0]           hit_way_o,
  output logic [WAY_W-1:0]           first_inv_o,
  output logic                       all_valid_o
);

  always_comb begin
    hit_o       = 1'b0;
    hit_way_o   = '0;
    first_inv_o = '0;
    all_valid_o = &valid_i;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (valid_i[i] && (tags_i[i] == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WAY_W'(i);
      end
    end
    // Scan from the top so the lowest invalid index is the last one written.
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!valid_i[WAYS-1-i]) begin
        first_inv_o = WAY_W'(WAYS - 1 - i);
      end
    end
  end

endmodule

// File: rtl/way_lookup_ctrl.sv
// Request sequencer for a 4-way set: lookup, dirty-victim writeback, fill and response.
module way_lookup_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned TAG_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [1:0]       resp_way,
  output logic [1:0]       lru_access_way,
  output logic             lru_access_valid,
  input  logic [1:0]       lru_evict_way,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  input  logic             wb_ready
);

  state_e                     state_q, state_d;
  op_e                        op_q, op_d;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic [WAY_W-1:0]           victim_q, victim_d;
  logic [WAYS-1:0]            valid_q, valid_d;
  logic [WAYS-1:0]            dirty_q, dirty_d;
  logic [WAYS-1:0][TAG_W-1:0] tags_q;
  logic                       tag_we;

  logic                       ready_q, ready_d;
  logic                       resp_valid_q, resp_valid_d;
  logic                       resp_hit_q, resp_hit_d;
  logic [WAY_W-1:0]           resp_way_q, resp_way_d;
  logic                       lru_valid_q, lru_valid_d;
  logic [WAY_W-1:0]           lru_way_q, lru_way_d;
  logic                       wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]           wb_tag_q, wb_tag_d;

  logic                       cmp_hit;
  logic [WAY_W-1:0]           cmp_hit_way;
  logic [WAY_W-1:0]           cmp_first_inv;
  logic                       cmp_all_valid;
  logic [WAY_W-1:0]           victim_sel;

  way_tag_compare #(
    .TAG_W (TAG_W)
  ) u_cmp (
    .tags_i      (tags_q),
    .valid_i     (valid_q),
    .tag_i       (tag_q),
    .hit_o       (cmp_hit),
    .hit_way_o   (cmp_hit_way),
    .first_inv_o (cmp_first_inv),
    .all_valid_o (cmp_all_valid)
  );

  assign victim_sel = cmp_all_valid ? lru_evict_way : cmp_first_inv;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tag_d        = tag_q;
    victim_d     = victim_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_we       = 1'b0;
    resp_hit_d   = 1'b0;
    resp_way_d   = '0;
    lru_valid_d  = 1'b0;
    lru_way_d    = '0;
    wb_valid_d   = 1'b0;
    wb_tag_d     = '0;

    unique case (state_q)
      ST_IDLE: begin
        // ready_q is low for the first cycle out of reset, so gate on it.
        if (ready_q && req_valid) begin
          op_d    = norm_op(req_op);
          tag_d   = req_tag;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (cmp_hit) begin
          resp_hit_d = 1'b1;
          resp_way_d = cmp_hit_way;
          state_d    = ST_RESP;
          if (op_q == OP_INVAL) begin
            valid_d[cmp_hit_way] = 1'b0;
            dirty_d[cmp_hit_way] = 1'b0;
          end else begin
            lru_valid_d = 1'b1;
            lru_way_d   = cmp_hit_way;
            if (op_q == OP_WRITE) dirty_d[cmp_hit_way] = 1'b1;
          end
        end else if (op_q == OP_INVAL) begin
          state_d = ST_RESP;
        end else begin
          victim_d = victim_sel;
          if (valid_q[victim_sel] && dirty_q[victim_sel]) begin
            wb_valid_d = 1'b1;
            wb_tag_d   = tags_q[victim_sel];
            state_d    = ST_WRITEBACK;
          end else begin
            lru_valid_d = 1'b1;
            lru_way_d   = victim_sel;
            state_d     = ST_FILL;
          end
        end
      end
      ST_WRITEBACK: begin
        if (wb_ready) begin
          lru_valid_d = 1'b1;
          lru_way_d   = victim_q;
          state_d     = ST_FILL;
        end else begin
          wb_valid_d = 1'b1;
          wb_tag_d   = wb_tag_q;
        end
      end
      ST_FILL: begin
        tag_we            = 1'b1;
        valid_d[victim_q] = 1'b1;
        dirty_d[victim_q] = (op_q == OP_WRITE);
        resp_way_d        = victim_q;
        state_d           = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d      = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_READ;
      tag_q        <= '0;
      victim_q     <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      lru_valid_q  <= 1'b0;
      lru_way_q    <= '0;
      wb_valid_q   <= 1'b0;
      wb_tag_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      victim_q     <= victim_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      lru_valid_q  <= lru_valid_d;
      lru_way_q    <= lru_way_d;
      wb_valid_q   <= wb_valid_d;
      wb_tag_q     <= wb_tag_d;
    end
  end

  // Tag array has no reset; entries are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (tag_we) tags_q[victim_q] <= tag_q;
  end

  assign req_ready        = ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_hit         = resp_hit_q;
  assign resp_way         = resp_way_q;
  assign lru_access_valid = lru_valid_q;
  assign lru_access_way   = lru_way_q;
  assign wb_valid         = wb_valid_q;
  assign wb_tag           = wb_tag_q;

endmodule

// File: tb/tb_way_lookup_ctrl.sv
// Directed plus randomized bench for way_lookup_ctrl against a behavioural cache-set model.
module tb_way_lookup_ctrl;

  localparam int TAG_W = 12;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_hit;
  logic [1:0]       resp_way;
  logic [1:0]       lru_access_way;
  logic             lru_access_valid;
  logic [1:0]       lru_evict_way;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_ready;

  int checks   = 0;
  int failures = 0;

  logic [TAG_W-1:0] mtag   [4];
  logic             mvalid [4];
  logic             mdirty [4];

  way_lookup_ctrl #(.TAG_W(TAG_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_tag          (req_tag),
    .resp_valid       (resp_valid),
    .resp_hit         (resp_hit),
    .resp_way         (resp_way),
    .lru_access_way   (lru_access_way),
    .lru_access_valid (lru_access_valid),
    .lru_evict_way    (lru_evict_way),
    .wb_valid         (wb_valid),
    .wb_tag           (wb_tag),
    .wb_ready         (wb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Issue one request; wb_ready is low for the first r cycles after accept.
  task automatic do_req(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                        input logic [1:0] ev, input int r);
    int eop, hw, v, exp_lat, exp_lru, exp_wb, exp_way, exp_lway;
    logic hit, exp_hit;
    logic [TAG_W-1:0] exp_wbtag;
    int lat, lru_cnt, wb_cnt, wb_bad, stray;
    logic rh, got;
    logic [1:0] rw, lway;

    eop = (op == 2'd3) ? 0 : int'(op);
    hit = 1'b0; hw = 0;
    for (int i = 0; i < 4; i++)
      if (mvalid[i] && mtag[i] == tag) begin hit = 1'b1; hw = i; end
    exp_wb = 0; exp_wbtag = '0; exp_lway = 0;
    if (eop == 2) begin
      exp_lat = 2; exp_hit = hit; exp_way = hit ? hw : 0; exp_lru = 0;
      if (hit) begin mvalid[hw] = 1'b0; mdirty[hw] = 1'b0; end
    end else if (hit) begin
      exp_lat = 2; exp_hit = 1'b1; exp_way = hw; exp_lru = 1; exp_lway = hw;
      if (eop == 1) mdirty[hw] = 1'b1;
    end else begin
      v = -1;
      for (int i = 3; i >= 0; i--) if (!mvalid[i]) v = i;
      if (v < 0) v = int'(ev);
      if (mvalid[v] && mdirty[v]) begin
        exp_wb = (r < 1) ? 1 : r;
        exp_wbtag = mtag[v];
      end
      exp_lat = 3 + exp_wb; exp_hit = 1'b0; exp_way = v; exp_lru = 1; exp_lway = v;
      mtag[v] = tag; mvalid[v] = 1'b1; mdirty[v] = (eop == 1);
    end

    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_tag = tag; lru_evict_way = ev; wb_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 0; lru_cnt = 0; wb_cnt = 0; wb_bad = 0; stray = 0;
    got = 1'b0; rh = 1'b0; rw = '0; lway = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      wb_ready = (c > r);
      if (req_ready) stray++;
      if (lru_access_valid) begin lru_cnt++; lway = lru_access_way; end
      else if (lru_access_way != 2'd0) stray++;
      if (wb_valid) begin
        wb_cnt++;
        if (wb_tag !== exp_wbtag) wb_bad++;
      end else if (wb_tag != '0) stray++;
      if (resp_valid) begin
        got = 1'b1; lat = c; rh = resp_hit; rw = resp_way;
        break;
      end else if (resp_hit || resp_way != 2'd0) stray++;
    end
    chk("resp_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_hit", 32'(rh), 32'(exp_hit));
    chk("resp_way", 32'(rw), 32'(exp_way));
    chk("lru_pulses", 32'(lru_cnt), 32'(exp_lru));
    if (exp_lru == 1) chk("lru_way", 32'(lway), 32'(exp_lway));
    chk("wb_cycles", 32'(wb_cnt), 32'(exp_wb));
    chk("wb_tag", 32'(wb_bad), 32'd0);
    chk("quiet_outputs", 32'(stray), 32'd0);
    @(negedge clk);
    wb_ready = 1'b0;
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin mvalid[i] = 1'b0; mdirty[i] = 1'b0; mtag[i] = '0; end
  endtask

  initial begin
    logic [TAG_W-1:0] rtag;
    int vdirty, found;
    rst = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_tag = '0;
    lru_evict_way = 2'd0; wb_ready = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_outs", 32'({resp_valid, resp_hit, resp_way, lru_access_valid, lru_access_way, wb_valid}), 32'd0);
    chk("rst_wbtag", 32'(wb_tag), 32'd0);
    rst = 1'b1;
    chk("ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ready_first_clock", 32'(req_ready), 32'd1);

    // Directed sequence
    do_req(2'd0, 12'h010, 2'd3, 0);
    do_req(2'd0, 12'h020, 2'd2, 0);
    do_req(2'd0, 12'h030, 2'd1, 0);
    do_req(2'd0, 12'h040, 2'd0, 0);
    do_req(2'd0, 12'h030, 2'd0, 0);
    do_req(2'd1, 12'h020, 2'd0, 0);
    do_req(2'd0, 12'h050, 2'd1, 3);
    do_req(2'd2, 12'h030, 2'd0, 0);
    do_req(2'd0, 12'h060, 2'd3, 0);
    do_req(2'd2, 12'h0AB, 2'd0, 0);
    do_req(2'd3, 12'h060, 2'd0, 0);

    // Randomized traffic over a small tag pool so hits, evictions and writebacks all occur
    for (int n = 0; n < 150; n++) begin
      do_req(2'($urandom_range(0, 3)), 12'($urandom_range(1, 9) * 16),
             2'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

    // Reset in the middle of a writeback
    for (int i = 0; i < 4; i++) do_req(2'd1, 12'(12'h100 + i), 2'(i), 0);
    vdirty = -1;
    for (int i = 0; i < 4; i++) if (mvalid[i] && mdirty[i]) vdirty = i;
    chk("setup_dirty", 32'(vdirty >= 0), 32'd1);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_tag = 12'h7FF;
    lru_evict_way = 2'(vdirty < 0 ? 0 : vdirty); wb_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (wb_valid) found = 1;
    end
    chk("wb_before_rst", 32'(found), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_ready_mid", 32'(req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    do_req(2'd0, 12'h010, 2'd2, 0);
    rtag = 12'h010;
    do_req(2'd0, rtag, 2'd1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
